// File: rtl/xnor_conv_feeder.sv
// Feeder/accumulator wrapped around an external XNOR-popcount PE array.
// Serial lane beats are packed into a full bundle for the PE. The PE results
// are sampled after a fixed latency and summed per lane over NUM_CHANNELS
// issues. The summed result is then held under a valid/ready handshake.
module xnor_conv_feeder #(
  parameter int NUMHELPER       = 4,
  parameter int INPUT_BITWIDTH  = 25,
  parameter int OUTPUT_BITWIDTH = 6,
  parameter int PE_LATENCY      = 1,
  parameter int NUM_CHANNELS    = 8,
  parameter int ACC_BITWIDTH    = 12
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [INPUT_BITWIDTH-1:0]             in_a,
  input  logic [INPUT_BITWIDTH-1:0]             in_b,
  output logic [NUMHELPER*INPUT_BITWIDTH-1:0]   pe_in_a,
  output logic [NUMHELPER*INPUT_BITWIDTH-1:0]   pe_in_b,
  input  logic [NUMHELPER*OUTPUT_BITWIDTH-1:0]  pe_out_c,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [NUMHELPER*ACC_BITWIDTH-1:0]     out_data
);

  localparam int LANE_W   = (NUMHELPER > 1) ? $clog2(NUMHELPER) : 1;
  localparam int CH_W     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SHADOW_N = (NUMHELPER > 1) ? NUMHELPER - 1 : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUMHELPER - 1);
  localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CHANNELS - 1);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, HOLD} state_t;

  state_t state, state_nxt;

  logic [LANE_W-1:0]          lane_cnt;
  logic [CH_W-1:0]            issue_cnt;
  logic [CH_W-1:0]            samp_cnt;
  logic [INPUT_BITWIDTH-1:0]  shadow_a [SHADOW_N];
  logic [INPUT_BITWIDTH-1:0]  shadow_b [SHADOW_N];
  logic [PE_LATENCY:0]        vld_p;
  logic signed [ACC_BITWIDTH-1:0] acc     [NUMHELPER];
  logic signed [ACC_BITWIDTH-1:0] acc_nxt [NUMHELPER];

  logic beat_fire;
  logic issue_fire;
  logic final_issue;
  logic samp_fire;
  logic last_samp;
  logic out_fire;

  // Sign-extend one PE lane result to accumulator width.
  function automatic logic signed [ACC_BITWIDTH-1:0] sext(
    input logic signed [OUTPUT_BITWIDTH-1:0] v
  );
    return ACC_BITWIDTH'(v);
  endfunction

  // Accumulator add; overflow wraps modulo 2^ACC_BITWIDTH.
  function automatic logic signed [ACC_BITWIDTH-1:0] acc_add(
    input logic signed [ACC_BITWIDTH-1:0] x,
    input logic signed [ACC_BITWIDTH-1:0] y
  );
    return x + y;
  endfunction

  assign beat_fire   = in_valid && in_ready;
  assign issue_fire  = beat_fire && (lane_cnt == LAST_LANE);
  assign final_issue = issue_fire && (issue_cnt == LAST_CH);
  assign samp_fire   = vld_p[PE_LATENCY];
  assign last_samp   = samp_fire && (samp_cnt == LAST_CH);
  assign out_fire    = out_valid && out_ready;

  // Group sequencing: next state and input back-pressure.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = final_issue ? DRAIN : FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        if (final_issue) state_nxt = DRAIN;
      end
      DRAIN: if (last_samp) state_nxt = HOLD;
      HOLD:  if (out_fire)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---- stage p0: lane packing into shadow buffer, full-bundle issue to PE
  // Beat packing: stage lanes in the shadow buffer, publish the whole bundle on issue.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lane_cnt  <= '0;
      issue_cnt <= '0;
      pe_in_a   <= '0;
      pe_in_b   <= '0;
      for (int j = 0; j < SHADOW_N; j++) begin
        shadow_a[j] <= '0;
        shadow_b[j] <= '0;
      end
    end else if (beat_fire) begin
      lane_cnt <= (lane_cnt == LAST_LANE) ? '0 : lane_cnt + 1'b1;
      if (issue_fire) begin
        issue_cnt <= (issue_cnt == LAST_CH) ? '0 : issue_cnt + 1'b1;
        for (int j = 0; j < NUMHELPER - 1; j++) begin
          pe_in_a[j*INPUT_BITWIDTH +: INPUT_BITWIDTH] <= shadow_a[j];
          pe_in_b[j*INPUT_BITWIDTH +: INPUT_BITWIDTH] <= shadow_b[j];
        end
        pe_in_a[(NUMHELPER-1)*INPUT_BITWIDTH +: INPUT_BITWIDTH] <= in_a;
        pe_in_b[(NUMHELPER-1)*INPUT_BITWIDTH +: INPUT_BITWIDTH] <= in_b;
      end else begin
        for (int j = 0; j < SHADOW_N; j++) begin
          if (lane_cnt == LANE_W'(j)) begin
            shadow_a[j] <= in_a;
            shadow_b[j] <= in_b;
          end
        end
      end
    end
  end

  // ---- stage p1..p(PE_LATENCY+1): PE latency tracking and accumulation
  // Per-lane next accumulator value: first sample of a group overwrites.
  always_comb begin
    for (int j = 0; j < NUMHELPER; j++) begin
      acc_nxt[j] = sext(pe_out_c[j*OUTPUT_BITWIDTH +: OUTPUT_BITWIDTH]);
      if (samp_cnt != '0) acc_nxt[j] = acc_add(acc[j], acc_nxt[j]);
    end
  end

  // Latency shift register, sample counter, accumulators and result handshake.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p     <= '0;
      samp_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int j = 0; j < NUMHELPER; j++) acc[j] <= '0;
    end else begin
      vld_p[0] <= issue_fire;
      for (int k = 1; k <= PE_LATENCY; k++) vld_p[k] <= vld_p[k-1];
      if (samp_fire) begin
        samp_cnt <= (samp_cnt == LAST_CH) ? '0 : samp_cnt + 1'b1;
        for (int j = 0; j < NUMHELPER; j++) acc[j] <= acc_nxt[j];
      end
      if (last_samp) begin
        out_valid <= 1'b1;
        for (int j = 0; j < NUMHELPER; j++)
          out_data[j*ACC_BITWIDTH +: ACC_BITWIDTH] <= acc_nxt[j];
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_xnor_conv_feeder.sv
// Directed bench for xnor_conv_feeder with a behavioural one-stage XNOR-popcount PE.
module tb_xnor_conv_feeder;

  localparam int N  = 4;
  localparam int IW = 25;
  localparam int OW = 6;
  localparam int AW = 12;
  localparam logic [IW-1:0] ONES = '1;

  logic            clock = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   in_a, in_b;
  logic [N*IW-1:0] pe_in_a, pe_in_b;
  logic [N*OW-1:0] pe_out_c = '0;
  logic            out_valid;
  logic            out_ready;
  logic [N*AW-1:0] out_data;

  int n_pass  = 0;
  int n_total = 0;

  logic ov_q      = 1'b0;
  int   ov_rises  = 0;

  xnor_conv_feeder dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .pe_in_a  (pe_in_a),
    .pe_in_b  (pe_in_b),
    .pe_out_c (pe_out_c),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clock = ~clock;

  function automatic logic [OW-1:0] pe_lane(input logic [IW-1:0] a, input logic [IW-1:0] b);
    return OW'(IW - 2 * $countones(a ^ b));
  endfunction

  // PE array model: one register stage.
  always @(posedge clock) begin
    for (int j = 0; j < N; j++)
      pe_out_c[j*OW +: OW] <= pe_lane(pe_in_a[j*IW +: IW], pe_in_b[j*IW +: IW]);
  end

  // Count out_valid rising edges.
  always @(posedge clock) begin
    ov_q <= out_valid;
    if (out_valid === 1'b1 && ov_q === 1'b0) ov_rises <= ov_rises + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic send_beat(input logic [IW-1:0] a, input logic [IW-1:0] b);
    int t;
    t = 0;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    if (t >= 100) chk("beat_ready_timeout", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int t;
    t = 0;
    while (out_valid !== 1'b1 && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    chk({tag, "_valid"}, out_valid, 1);
  endtask

  task automatic collect(input string tag, input logic [N*AW-1:0] exp);
    wait_valid(tag);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk({tag, "_cleared"}, out_valid, 0);
  endtask

  logic [IW-1:0]   a, b;
  logic [IW-1:0]   hist_a [N];
  logic [IW-1:0]   hist_b [N];
  logic [N*IW-1:0] prev_a, prev_b;
  logic [N*AW-1:0] held, exp_data;
  int              bad, r0, hold_n;
  int              ref_sum [N];

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_pe_in_a", pe_in_a, 0);
    chk("rst_pe_in_b", pe_in_b, 0);
    reset = 1'b1;
    chk("rst_in_ready_first", in_ready, 1);

    // T1: all-ones operands, +25 per issue, +200 per lane; latency of result
    for (int k = 0; k < 32; k++) send_beat(ONES, ONES);
    chk("t1_in_ready_drain", in_ready, 0);
    chk("t1_not_early0", out_valid, 0);
    @(posedge clock); #1;
    chk("t1_not_early1", out_valid, 0);
    @(posedge clock); #1;
    chk("t1_latency", out_valid, 1);
    collect("t1", {4{12'h0C8}});
    chk("t1_in_ready_after", in_ready, 1);

    // T2: complemented weights, -200 per lane (also proves overwrite on new group)
    for (int k = 0; k < 32; k++) begin
      a = 25'h0A5A5A5 ^ IW'(k * 131);
      b = ~a;
      send_beat(a, b);
    end
    collect("t2", {4{12'hF38}});

    // T3: lane 0 equal, others complemented; pe_in_* change only on issue beats
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      a = IW'(k * 7919 + 3);
      b = (k % 4 == 0) ? a : ~a;
      hist_a[k % 4] = a;
      hist_b[k % 4] = b;
      prev_a = pe_in_a;
      prev_b = pe_in_b;
      send_beat(a, b);
      if (k % 4 == 3) begin
        if (pe_in_a !== {hist_a[3], hist_a[2], hist_a[1], hist_a[0]} ||
            pe_in_b !== {hist_b[3], hist_b[2], hist_b[1], hist_b[0]}) bad++;
      end else if (pe_in_a !== prev_a || pe_in_b !== prev_b) begin
        bad++;
      end
    end
    chk("t3_pe_in_bundle", bad, 0);
    collect("t3", 48'hF38F38F380C8);

    // T4: consumer stalls 10 cycles
    for (int k = 0; k < 32; k++) send_beat(ONES, ONES);
    wait_valid("t4");
    held = out_data;
    chk("t4_data", held, {4{12'h0C8}});
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1;
      in_a = IW'($urandom);
      in_b = IW'($urandom);
      @(posedge clock); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) bad++;
    end
    in_valid = 1'b0;
    chk("t4_stall_stable", bad, 0);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("t4_valid_cleared", out_valid, 0);
    chk("t4_in_ready_back", in_ready, 1);
    chk("t4_data_kept", out_data, held);

    // T5: reset mid-group after 13 beats, then a clean group
    for (int k = 0; k < 13; k++) send_beat(ONES, ~ONES);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("t5_rst_pe_in_a", pe_in_a, 0);
    chk("t5_rst_out_data", out_data, 0);
    reset = 1'b1;
    chk("t5_in_ready_first", in_ready, 1);
    r0 = ov_rises;
    repeat (6) @(posedge clock);
    #1;
    chk("t5_no_stale_valid", ov_rises - r0, 0);
    for (int k = 0; k < 32; k++) send_beat(ONES, ONES);
    collect("t5", {4{12'h0C8}});
    chk("t5_single_result", ov_rises - r0, 1);

    // T6: random operands, random in_valid gaps and out_ready
    for (int g = 0; g < 20; g++) begin
      for (int j = 0; j < N; j++) ref_sum[j] = 0;
      for (int k = 0; k < 32; k++) begin
        a = IW'($urandom);
        b = IW'($urandom);
        ref_sum[k % 4] += IW - 2 * $countones(a ^ b);
        repeat ($urandom_range(0, 2)) begin
          in_valid  = 1'b0;
          in_a      = IW'($urandom);
          in_b      = IW'($urandom);
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clock); #1;
        end
        out_ready = 1'($urandom_range(0, 1));
        send_beat(a, b);
      end
      exp_data = '0;
      for (int j = 0; j < N; j++) exp_data[j*AW +: AW] = AW'(ref_sum[j]);
      out_ready = 1'b0;
      wait_valid($sformatf("t6_g%0d", g));
      chk($sformatf("t6_g%0d_data", g), out_data, exp_data);
      held   = out_data;
      bad    = 0;
      hold_n = $urandom_range(0, 5);
      for (int c = 0; c < hold_n; c++) begin
        @(posedge clock); #1;
        if (out_valid !== 1'b1 || out_data !== held) bad++;
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      out_ready = 1'b0;
      if (out_valid !== 1'b0) bad++;
      chk($sformatf("t6_g%0d_handshake", g), bad, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/xnor_conv_feeder.md
XNOR_CONV_FEEDER -- requirements
Module: xnor_conv_feeder

Interface
REQ-001 SHALL have parameter NUMHELPER, default 4: number of PE lanes.
REQ-002 SHALL have parameter INPUT_BITWIDTH, default 25: bits per lane operand.
REQ-003 SHALL have parameter OUTPUT_BITWIDTH, default 6: bits per lane PE result, two's complement.
REQ-004 SHALL have parameter PE_LATENCY, default 1: PE register stages.
REQ-005 SHALL have parameter NUM_CHANNELS, default 8: issues accumulated per output.
REQ-006 SHALL have parameter ACC_BITWIDTH, default 12: bits per lane accumulator, two's complement.
REQ-007 SHALL have port clock, input, 1: the only clock; all state changes on its rising edge.
REQ-008 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-009 SHALL have port in_valid, input, 1: lane operand beat valid.
REQ-010 SHALL have port in_ready, output, 1: beat accepted when in_valid && in_ready at an edge.
REQ-011 SHALL have port in_a, input, INPUT_BITWIDTH: activation window bits for the current lane.
REQ-012 SHALL have port in_b, input, INPUT_BITWIDTH: weight bits for the current lane.
REQ-013 SHALL have port pe_in_a, output, NUMHELPER*INPUT_BITWIDTH: packed activations to PE; lane j at bits [j*INPUT_BITWIDTH +: INPUT_BITWIDTH].
REQ-014 SHALL have port pe_in_b, output, NUMHELPER*INPUT_BITWIDTH: packed weights to PE, same lane layout.
REQ-015 SHALL have port pe_out_c, input, NUMHELPER*OUTPUT_BITWIDTH: PE results; lane j at [j*OUTPUT_BITWIDTH +: OUTPUT_BITWIDTH].
REQ-016 SHALL have port out_valid, output, 1: accumulated result available.
REQ-017 SHALL have port out_ready, input, 1: consumer accepts result when out_valid && out_ready at an edge.
REQ-018 SHALL have port out_data, output, NUMHELPER*ACC_BITWIDTH: per-lane sums; lane j at [j*ACC_BITWIDTH +: ACC_BITWIDTH].

Function
REQ-019 SHALL pack accepted beats into lanes in order 0..NUMHELPER-1 using a lane counter that wraps to 0 after lane NUMHELPER-1.
REQ-020 SHALL update pe_in_a/pe_in_b with the full bundle at the edge accepting lane NUMHELPER-1 beat (issue edge), then hold them unchanged until the next issue.
REQ-021 SHALL stage lanes 0..NUMHELPER-2 in a shadow buffer so pe_in_* never shows a partial bundle.
REQ-022 SHALL sample pe_out_c exactly PE_LATENCY+1 edges after each issue edge, tracked by a valid shift register, one bit per stage.
REQ-023 SHALL sign-extend each OUTPUT_BITWIDTH lane result to ACC_BITWIDTH and add it to that lane's accumulator; overflow wraps modulo 2^ACC_BITWIDTH.
REQ-024 SHALL count issues 0..NUM_CHANNELS-1; the first sample of a group overwrites accumulators instead of adding.
REQ-025 SHALL, at the edge sampling the NUM_CHANNELS-th result, load out_data and set out_valid.
REQ-026 SHALL hold out_valid and out_data stable until the accepting edge, then clear out_valid at that edge; out_data keeps its last value.
REQ-027 SHALL use states IDLE (no beats in group), FILL (accepting beats), DRAIN (final issue done, awaiting last sample), HOLD (out_valid high); IDLE->FILL on first beat, FILL->DRAIN on final issue, DRAIN->HOLD on last sample, HOLD->IDLE on acceptance.
REQ-028 SHALL drive in_ready high in IDLE and FILL, low in DRAIN and HOLD.
REQ-029 SHALL, when out_valid and out_ready are both high in HOLD, return in_ready high on the next cycle.
REQ-030 SHALL allow consecutive issues on back-to-back cycles with no dependence on pending samples within a group.
REQ-031 SHALL ignore in_a/in_b when in_valid is low and ignore out_ready when out_valid is low.

Reset
REQ-032 SHALL, while reset is low at an edge, clear pe_in_a, pe_in_b, out_data, out_valid, shadow buffer, accumulators, lane/issue counters and latency shift register; state becomes IDLE.
REQ-033 SHALL drive in_ready high on the first cycle after reset deasserts.
REQ-034 SHALL discard any partial bundle, in-flight samples and held result when reset is low mid-operation; no out_valid pulse follows.

Verification
REQ-035 SHALL pass: 32 beats with in_a=in_b=all-ones -> one out_valid, every lane = +200 (0x0C8).
REQ-036 SHALL pass: 32 beats with in_b=~in_a -> every lane = -200 (0xF38).
REQ-037 SHALL pass: lane0 equal, lanes1-3 complemented, 32 beats -> lanes = +200, -200, -200, -200; pe_in_* change only on every 4th accepted beat.
REQ-038 SHALL pass: out_ready low 10 cycles after out_valid -> out_data stable, in_ready low throughout, in_ready high one cycle after acceptance.
REQ-039 SHALL pass: reset low after 13 beats, then 32 all-ones beats -> single result +200 per lane, no stale output.
REQ-040 SHALL pass: random operands, 20 groups, in_valid and out_ready toggled randomly -> per-lane sums match reference sum of (25 - 2*popcount(a^b)).
